// File: rtl/mux4_rr_arbiter.sv
// Purpose: 4-requester round-robin arbiter that steers the granted requester's data bit onto a shared output.
// Latency: the grant is registered one cycle after the request is sampled in IDLE; z is combinational from d while granted.
// Backpressure: an owner keeps the grant for at most MAX_HOLD cycles; other requests are not queued while a grant is held.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       z,
    output logic       busy,
    output logic       preempt
);

    // The hold counter needs to count 0..MAX_HOLD-1 only, because the grant ends on the last value.
    localparam int              CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             preempt_q, preempt_d;

    logic             pick_vld;
    logic [1:0]       pick_idx;
    logic [1:0]       cand;
    logic             owner_req;
    logic             hold_done;

    // Round-robin pick: scan from ptr upward; descending loop so the nearest requester is written last and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        cand     = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign owner_req = req[sel_q];
    assign hold_done = (cnt_q == CNT_LAST);

    // Next-state and next-output logic; release wins over timeout so preempt only marks a forced end.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                gnt_d = 4'b0000;
                if (pick_vld) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = 4'(4'b0001 << pick_idx);
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    state_d = ST_GAP;
                    gnt_d   = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
                end else if (hold_done) begin
                    state_d   = ST_GAP;
                    gnt_d     = 4'b0000;
                    ptr_d     = sel_q + 2'd1;
                    preempt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                // One dead cycle between owners, whatever req is doing.
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset drops the grant at once with no GAP or preempt.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = (state_q == ST_GRANT);
    assign preempt = preempt_q;
    // Shared 4->1 mux, gated so the resource output is quiet whenever nobody owns it.
    assign z       = busy & d[sel_q];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Purpose: directed self-checking bench for mux4_rr_arbiter with MAX_HOLD=8.
// Latency: inputs change 1ns after a rising edge; outputs are inspected 1ns after the edge that should produce them.
// Backpressure: not applicable; a per-cycle monitor checks grant legality on every falling edge.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       resetN;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       z;
    logic       busy;
    logic       preempt;

    int total;
    int bad;

    logic [3:0] req_s;
    logic [3:0] gnt_before;

    mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .resetN  (resetN),
        .req     (req),
        .d       (d),
        .gnt     (gnt),
        .sel     (sel),
        .z       (z),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture what the arbiter saw at each edge for the grant-legality check.
    always @(posedge clk) begin
        req_s      <= req;
        gnt_before <= gnt;
    end

    // Per-cycle invariants: one-hot grant, quiet output when ungranted, grants only to requesters.
    always @(negedge clk) begin
        if (resetN === 1'b1) begin
            total++;
            if (!$onehot0(gnt)) begin
                bad++;
                $display("FAIL monitor_onehot: gnt=%b is not one-hot or zero", gnt);
            end
            total++;
            if (gnt === 4'b0000 && z !== 1'b0) begin
                bad++;
                $display("FAIL monitor_z_quiet: z=%b while gnt=0000, want 0", z);
            end
            if (gnt_before === 4'b0000 && gnt !== 4'b0000) begin
                total++;
                if ((gnt & ~req_s) !== 4'b0000) begin
                    bad++;
                    $display("FAIL monitor_gnt_req: gnt=%b but req at arbitration=%b", gnt, req_s);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetN = 1'b0;
        req    = 4'b0000;
        cyc();
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        req    = 4'b0000;
        d      = 4'b1111;
        cyc();
        total++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || z !== 1'b0 || busy !== 1'b0 || preempt !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b sel=%0d z=%b busy=%b preempt=%b, want 0000 0 0 0 0",
                     gnt, sel, z, busy, preempt);
        end
        cyc();
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_no_req: cycle %0d gnt=%b busy=%b, want 0000 0", i, gnt, busy);
            end
        end
    endtask

    task automatic test_single_timeout();
        apply_reset();
        req = 4'b0100;
        d   = 4'b0100;
        cyc();
        total++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1 || z !== 1'b1) begin
            bad++;
            $display("FAIL single_grant: gnt=%b sel=%0d busy=%b z=%b, want 0100 2 1 1", gnt, sel, busy, z);
        end
        d = 4'b0000;
        #1;
        total++;
        if (z !== 1'b0) begin
            bad++;
            $display("FAIL single_z_follow: z=%b with d[2]=0, want 0", z);
        end
        d = 4'b0100;
        for (int i = 1; i < 8; i++) cyc();
        total++;
        if (gnt !== 4'b0100 || preempt !== 1'b0) begin
            bad++;
            $display("FAIL single_hold8: gnt=%b preempt=%b in 8th cycle, want 0100 0", gnt, preempt);
        end
        cyc();
        total++;
        if (gnt !== 4'b0000 || preempt !== 1'b1 || busy !== 1'b0 || sel !== 2'd2 || z !== 1'b0) begin
            bad++;
            $display("FAIL single_timeout: gnt=%b preempt=%b busy=%b sel=%0d z=%b, want 0000 1 0 2 0",
                     gnt, preempt, busy, sel, z);
        end
        req = 4'b1111;
        cyc();
        total++;
        if (gnt !== 4'b0000 || preempt !== 1'b0) begin
            bad++;
            $display("FAIL single_idle_after_gap: gnt=%b preempt=%b, want 0000 0", gnt, preempt);
        end
        cyc();
        total++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            bad++;
            $display("FAIL single_ptr_next: gnt=%b sel=%0d, want 1000 3", gnt, sel);
        end
        req = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_idx;
        logic [3:0] exp_gnt;
        logic [3:0] dv;
        apply_reset();
        dv  = 4'b1010;
        d   = dv;
        req = 4'b1111;
        cyc();
        for (int g = 0; g < 5; g++) begin
            exp_idx = 2'(g % 4);
            exp_gnt = 4'b0001 << exp_idx;
            for (int c = 0; c < 8; c++) begin
                total++;
                if (gnt !== exp_gnt || sel !== exp_idx || z !== dv[exp_idx] || preempt !== 1'b0) begin
                    bad++;
                    $display("FAIL rr_grant: grant %0d cycle %0d gnt=%b sel=%0d z=%b preempt=%b, want %b %0d %b 0",
                             g, c, gnt, sel, z, preempt, exp_gnt, exp_idx, dv[exp_idx]);
                end
                cyc();
            end
            total++;
            if (gnt !== 4'b0000 || preempt !== 1'b1) begin
                bad++;
                $display("FAIL rr_gap: after grant %0d gnt=%b preempt=%b, want 0000 1", g, gnt, preempt);
            end
            cyc();
            total++;
            if (gnt !== 4'b0000 || preempt !== 1'b0) begin
                bad++;
                $display("FAIL rr_idle: after grant %0d gnt=%b preempt=%b, want 0000 0", g, gnt, preempt);
            end
            cyc();
        end
        req = 4'b0000;
    endtask

    task automatic test_release();
        apply_reset();
        req = 4'b0010;
        d   = 4'b0010;
        cyc();
        total++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            bad++;
            $display("FAIL release_grant: gnt=%b sel=%0d, want 0010 1", gnt, sel);
        end
        cyc();
        cyc();
        total++;
        if (gnt !== 4'b0010 || busy !== 1'b1) begin
            bad++;
            $display("FAIL release_held3: gnt=%b busy=%b, want 0010 1", gnt, busy);
        end
        req = 4'b0000;
        cyc();
        total++;
        if (gnt !== 4'b0000 || preempt !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL release_gap: gnt=%b preempt=%b busy=%b, want 0000 0 0", gnt, preempt, busy);
        end
        req = 4'b1010;
        cyc();
        total++;
        if (gnt !== 4'b0000) begin
            bad++;
            $display("FAIL release_idle: gnt=%b, want 0000", gnt);
        end
        cyc();
        total++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            bad++;
            $display("FAIL release_next_owner: gnt=%b sel=%0d, want 1000 3", gnt, sel);
        end
        req = 4'b0000;
    endtask

    task automatic test_release_at_limit();
        apply_reset();
        req = 4'b0001;
        d   = 4'b0000;
        cyc();
        for (int i = 1; i < 8; i++) cyc();
        total++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            bad++;
            $display("FAIL limit_last_cycle: gnt=%b busy=%b, want 0001 1", gnt, busy);
        end
        req = 4'b0000;
        cyc();
        total++;
        if (gnt !== 4'b0000 || preempt !== 1'b0) begin
            bad++;
            $display("FAIL limit_release_wins: gnt=%b preempt=%b, want 0000 0", gnt, preempt);
        end
        req = 4'b0011;
        cyc();
        cyc();
        total++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            bad++;
            $display("FAIL limit_next_owner: gnt=%b sel=%0d, want 0010 1", gnt, sel);
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        req = 4'b0100;
        d   = 4'b0100;
        cyc();
        cyc();
        total++;
        if (gnt !== 4'b0100 || z !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre: gnt=%b z=%b, want 0100 1", gnt, z);
        end
        resetN = 1'b0;
        #1;
        total++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || z !== 1'b0 || busy !== 1'b0 || preempt !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async: gnt=%b sel=%0d z=%b busy=%b preempt=%b, want 0000 0 0 0 0",
                     gnt, sel, z, busy, preempt);
        end
        req = 4'b0110;
        cyc();
        total++;
        if (gnt !== 4'b0000 || preempt !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_pulse: gnt=%b preempt=%b, want 0000 0", gnt, preempt);
        end
        resetN = 1'b1;
        cyc();
        total++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            bad++;
            $display("FAIL midrst_ptr0: gnt=%b sel=%0d, want 0010 1", gnt, sel);
        end
        req = 4'b0000;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        resetN = 1'b0;
        req    = 4'b0000;
        d      = 4'b0000;
        test_reset();
        test_single_timeout();
        test_round_robin();
        test_release();
        test_release_at_limit();
        test_reset_mid_grant();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum consecutive cycles one requester holds the grant (legal range 2..256).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetN  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port req  input  4  per-requester request; bit i belongs to requester i.
REQ-005 The block SHALL have port d  input  4  per-requester 1-bit data; bit i is the data of requester i.
REQ-006 The block SHALL have port gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 The block SHALL have port sel  output  2  registered index of the current or last owner; drives the shared 4->1 mux select.
REQ-008 The block SHALL have port z  output  1  shared-resource output: d[sel] while granted, else 0.
REQ-009 The block SHALL have port busy  output  1  high while in GRANT.
REQ-010 The block SHALL have port preempt  output  1  one-cycle pulse when a grant ends by timeout.

Function
REQ-011 The block SHALL implement states IDLE, GRANT, GAP.
REQ-012 In IDLE with req==0, the block SHALL remain in IDLE with gnt=0.
REQ-013 In IDLE with req!=0, the block SHALL select the first asserted requester scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4), load sel and gnt with it, clear the hold counter and enter GRANT on the next edge.
REQ-014 Grant latency SHALL be one cycle: req sampled high in IDLE at edge k gives gnt high after edge k.
REQ-015 In GRANT, the hold counter (width clog2(MAX_HOLD)) SHALL increment by 1 each cycle and never wrap within one grant.
REQ-016 In GRANT, if req[sel]==0, the block SHALL enter GAP on the next edge with gnt=0 and preempt=0.
REQ-017 In GRANT, if req[sel]==1 and counter==MAX_HOLD-1, the block SHALL enter GAP with gnt=0 and pulse preempt=1 for exactly that GAP cycle, so the grant lasts exactly MAX_HOLD cycles.
REQ-018 If release and timeout coincide, release SHALL take precedence (preempt=0).
REQ-019 On any GRANT exit, ptr SHALL be loaded with sel+1 mod 4 (index 3 wraps to 0).
REQ-020 GAP SHALL last exactly one cycle with gnt=0, then go to IDLE regardless of req.
REQ-021 Minimum spacing between two grants SHALL be 2 idle cycles (GAP + IDLE arbitration).
REQ-022 sel SHALL hold its value outside GRANT; z SHALL be 0 whenever gnt==0.
REQ-023 z SHALL be combinational from d and sel while busy, with no added latency.
REQ-024 Requests from non-owners during GRANT SHALL be ignored until the next IDLE arbitration; they are not stored.
REQ-025 gnt SHALL never have more than one bit set.

Reset
REQ-026 On resetN low, the block SHALL asynchronously force state=IDLE, gnt=0, sel=0, ptr=0, counter=0, busy=0, preempt=0, z=0.
REQ-027 Reset asserted mid-GRANT SHALL drop gnt in the same cycle, without a GAP cycle and without a preempt pulse.
REQ-028 After resetN deasserts, the first arbitration SHALL start from ptr=0.

Verification
REQ-029 Reset, then req=0100 held -> gnt=0100, sel=2 one cycle later; z follows d[2]; after 8 cycles preempt=1, gnt=0000, ptr=3.
REQ-030 req=1111 held continuously, MAX_HOLD=8 -> grants in order 0,1,2,3,0, each 8 cycles long with 2-cycle gaps, preempt pulsing after each grant.
REQ-031 Grant to 1, drop req[1] after 3 granted cycles -> GAP with preempt=0, then with req=1010 next grant goes to 3, not 1.
REQ-032 req[sel] drops on the cycle counter==7 -> GAP with preempt=0.
REQ-033 Pulse resetN low mid-GRANT to 2 -> gnt=0, sel=0, z=0 immediately; after release with req=0110 -> grant to 1.
REQ-034 Every cycle of every test -> gnt one-hot or zero, z=0 whenever gnt=0, and gnt[i] only if req[i] was high at the arbitration edge.
